// File: rtl/systolic_result_drain.sv
// systolic_result_drain
//
// Output-side companion to the 2x2 systolic matrix multiplier. When the MAC
// array pulses acc_done, the four accumulators are saturated from ACC_WIDTH
// to OUT_WIDTH and captured. The next cycle acc_clear tells the array to zero
// its accumulators. The captured matrix is then streamed out one row per
// valid/ready handshake, row 0 first.
//
// Ports:
//   clk        single clock, all state changes on posedge
//   reset      synchronous, active-high
//   acc_in     flat accumulators, C[r][c] at acc_in[ACC_WIDTH*(2*r+c) +: ACC_WIDTH]
//   acc_done   one-cycle pulse: acc_in holds a final result
//   acc_clear  one-cycle pulse to zero the array accumulators
//   out_valid  out_data holds a valid row
//   out_ready  downstream accepts the row on out_valid && out_ready
//   out_data   row {C[r][1], C[r][0]}, element 0 in the low bits
//   out_row    row index r
//   out_last   high with row 1
//   out_sat    at least one element of the current row was clamped
//   busy       FSM is not idle
//   drop_err   sticky flag: an acc_done pulse was ignored

module systolic_result_drain #(
    parameter int OP_WIDTH  = 8,
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [4*ACC_WIDTH-1:0]   acc_in,
    input  logic                     acc_done,
    output logic                     acc_clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*OUT_WIDTH-1:0]   out_data,
    output logic                     out_row,
    output logic                     out_last,
    output logic                     out_sat,
    output logic                     busy,
    output logic                     drop_err
);

    // Reject parameter sets the saturation logic cannot handle.
    if (OUT_WIDTH < 2 || OUT_WIDTH > ACC_WIDTH || OP_WIDTH < 1) begin : g_param_check
        $error("systolic_result_drain: illegal OP_WIDTH/ACC_WIDTH/OUT_WIDTH combination");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROW0 = 2'd1,
        ROW1 = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [OUT_WIDTH-1:0] elem_q [4];
    logic [1:0]           row_sat_q;
    logic                 acc_clear_q;
    logic                 drop_err_q;

    logic [OUT_WIDTH:0]   sat_res [4];
    logic                 handshake;
    logic                 capture;
    logic                 drop;

    // A value fits in OUT_WIDTH bits exactly when its bits from the output
    // sign position upwards are all equal. When OUT_WIDTH == ACC_WIDTH that
    // range is just the sign bit, so everything passes through unclamped.
    // Result is {clamped_flag, value}.
    function automatic logic [OUT_WIDTH:0] saturate(input logic [ACC_WIDTH-1:0] x);
        logic [ACC_WIDTH-OUT_WIDTH:0] upper;
        upper = x[ACC_WIDTH-1:OUT_WIDTH-1];
        if ((&upper) || !(|upper)) begin
            return {1'b0, x[OUT_WIDTH-1:0]};
        end else if (x[ACC_WIDTH-1]) begin
            return {1'b1, 1'b1, {(OUT_WIDTH-1){1'b0}}};
        end else begin
            return {1'b1, 1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            sat_res[i] = saturate(acc_in[ACC_WIDTH*i +: ACC_WIDTH]);
        end
    end

    // A pulse is taken only from IDLE or on the row-1 handshake; anywhere
    // else in the drain it would overwrite a matrix still being streamed.
    always_comb begin
        handshake = (state != IDLE) && out_ready;
        capture   = acc_done && ((state == IDLE) || (state == ROW1 && out_ready));
        drop      = acc_done && ((state == ROW0) || (state == ROW1 && !out_ready));
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (acc_done) state_next = ROW0;
            end
            ROW0: begin
                if (handshake) state_next = ROW1;
            end
            ROW1: begin
                if (handshake) state_next = acc_done ? ROW0 : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Captured matrix, per-row clamp flags, clear pulse and sticky drop flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                elem_q[i] <= '0;
            end
            row_sat_q   <= 2'b00;
            acc_clear_q <= 1'b0;
            drop_err_q  <= 1'b0;
        end else begin
            acc_clear_q <= capture;
            if (drop) begin
                drop_err_q <= 1'b1;
            end
            if (capture) begin
                for (int i = 0; i < 4; i++) begin
                    elem_q[i] <= sat_res[i][OUT_WIDTH-1:0];
                end
                row_sat_q[0] <= sat_res[0][OUT_WIDTH] | sat_res[1][OUT_WIDTH];
                row_sat_q[1] <= sat_res[2][OUT_WIDTH] | sat_res[3][OUT_WIDTH];
            end
        end
    end

    // Output logic: row outputs are driven only while a row is valid, so the
    // idle bus reads as zero.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_row   = 1'b0;
        out_last  = 1'b0;
        out_sat   = 1'b0;
        busy      = 1'b0;
        case (state)
            ROW0: begin
                out_valid = 1'b1;
                out_data  = {elem_q[1], elem_q[0]};
                out_sat   = row_sat_q[0];
                busy      = 1'b1;
            end
            ROW1: begin
                out_valid = 1'b1;
                out_data  = {elem_q[3], elem_q[2]};
                out_row   = 1'b1;
                out_last  = 1'b1;
                out_sat   = row_sat_q[1];
                busy      = 1'b1;
            end
            default: begin
            end
        endcase
        acc_clear = acc_clear_q;
        drop_err  = drop_err_q;
    end

endmodule

// File: tb/tb_systolic_result_drain.sv
// tb_systolic_result_drain
//
// Self-checking bench for systolic_result_drain (ACC_WIDTH=32, OUT_WIDTH=16).
// A table of matrices with hand-computed rows is drained first, followed by
// hand-written sequences for backpressure, back-to-back capture, dropped
// pulses and mid-drain reset, then a few random matrices. Every accepted
// matrix pushes its expected rows onto a scoreboard queue; a monitor pops and
// compares one entry per output handshake.

module tb_systolic_result_drain;

    localparam int ACC_WIDTH = 32;
    localparam int OUT_WIDTH = 16;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [4*ACC_WIDTH-1:0] acc_in;
    logic                   acc_done;
    logic                   acc_clear;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*OUT_WIDTH-1:0] out_data;
    logic                   out_row;
    logic                   out_last;
    logic                   out_sat;
    logic                   busy;
    logic                   drop_err;

    always #5 clk = ~clk;

    systolic_result_drain #(
        .OP_WIDTH  (8),
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .acc_in    (acc_in),
        .acc_done  (acc_done),
        .acc_clear (acc_clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_last  (out_last),
        .out_sat   (out_sat),
        .busy      (busy),
        .drop_err  (drop_err)
    );

    typedef struct {
        logic [31:0] data;
        logic        row;
        logic        sat;
    } exp_t;

    typedef struct {
        logic signed [31:0] c00;
        logic signed [31:0] c01;
        logic signed [31:0] c10;
        logic signed [31:0] c11;
        logic [31:0]        row0;
        logic               sat0;
        logic [31:0]        row1;
        logic               sat1;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[5];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Reference saturation: {clamped, value}
    function automatic logic [16:0] model_sat(input logic signed [31:0] x);
        if (x > 32'sd32767)       return {1'b1, 16'h7FFF};
        else if (x < -32'sd32768) return {1'b1, 16'h8000};
        else                      return {1'b0, x[15:0]};
    endfunction

    function automatic logic [127:0] pack4(input logic signed [31:0] c00, input logic signed [31:0] c01,
                                           input logic signed [31:0] c10, input logic signed [31:0] c11);
        return {c11, c10, c01, c00};
    endfunction

    task automatic pushRows(input logic [31:0] r0, input logic s0, input logic [31:0] r1, input logic s1);
        exp_t e;
        e.data = r0; e.row = 1'b0; e.sat = s0;
        sb.push_back(e);
        e.data = r1; e.row = 1'b1; e.sat = s1;
        sb.push_back(e);
    endtask

    task automatic pushMatrix(input logic signed [31:0] c00, input logic signed [31:0] c01,
                              input logic signed [31:0] c10, input logic signed [31:0] c11);
        logic [16:0] s00, s01, s10, s11;
        s00 = model_sat(c00); s01 = model_sat(c01);
        s10 = model_sat(c10); s11 = model_sat(c11);
        pushRows({s01[15:0], s00[15:0]}, s00[16] | s01[16],
                 {s11[15:0], s10[15:0]}, s10[16] | s11[16]);
    endtask

    task automatic applyStimulus(input logic [127:0] acc, input logic done, input logic ready);
        acc_in    = acc;
        acc_done  = done;
        out_ready = ready;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic signed [31:0] rand_elem();
        logic [31:0] r;
        case ($urandom_range(0, 2))
            0: begin
                r = 32'($urandom_range(0, 65535));
                return r - 32'd32768;
            end
            1: return $urandom;
            default: return ($urandom_range(0, 1) != 0) ? 32'sd32768 : -32'sd32769;
        endcase
    endfunction

    // Scoreboard monitor: one comparison set per accepted row.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("[TB] FAIL sb_unexpected_row: got row %0d data 0x%08h, expected no row", out_row, out_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("sb_data", out_data, e.data);
                checkOutput("sb_row", 32'(out_row), 32'(e.row));
                checkOutput("sb_last", 32'(out_last), 32'(e.row));
                checkOutput("sb_sat", 32'(out_sat), 32'(e.sat));
            end
        end
    end

    initial begin
        logic [127:0] m;
        logic signed [31:0] r00, r01, r10, r11;

        vecs[0] = '{c00: 1, c01: 2, c10: 3, c11: 4,
                    row0: 32'h0002_0001, sat0: 1'b0, row1: 32'h0004_0003, sat1: 1'b0};
        vecs[1] = '{c00: 40000, c01: -40000, c10: 32767, c11: -32768,
                    row0: 32'h8000_7FFF, sat0: 1'b1, row1: 32'h8000_7FFF, sat1: 1'b0};
        vecs[2] = '{c00: -1, c01: 0, c10: -32769, c11: 65536,
                    row0: 32'h0000_FFFF, sat0: 1'b0, row1: 32'h7FFF_8000, sat1: 1'b1};
        vecs[3] = '{c00: 32'sh7FFF_FFFF, c01: 32'sh8000_0000, c10: 100, c11: -100,
                    row0: 32'h8000_7FFF, sat0: 1'b1, row1: 32'hFF9C_0064, sat1: 1'b0};
        vecs[4] = '{c00: 32768, c01: 5, c10: -5, c11: -32768,
                    row0: 32'h0005_7FFF, sat0: 1'b1, row1: 32'h8000_FFFB, sat1: 1'b0};

        // Reset state
        reset = 1'b1;
        applyStimulus('0, 1'b0, 1'b0);
        step();
        step();
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_data", out_data, 32'd0);
        checkOutput("rst_row", 32'(out_row), 32'd0);
        checkOutput("rst_last", 32'(out_last), 32'd0);
        checkOutput("rst_sat", 32'(out_sat), 32'd0);
        checkOutput("rst_clear", 32'(acc_clear), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_drop", 32'(drop_err), 32'd0);
        reset = 1'b0;
        step();

        // Table-driven drains with out_ready held high
        for (int i = 0; i < 5; i++) begin
            m = pack4(vecs[i].c00, vecs[i].c01, vecs[i].c10, vecs[i].c11);
            applyStimulus(m, 1'b1, 1'b1);
            pushRows(vecs[i].row0, vecs[i].sat0, vecs[i].row1, vecs[i].sat1);
            step();
            applyStimulus(m, 1'b0, 1'b1);
            checkOutput("tbl_t1_valid", 32'(out_valid), 32'd1);
            checkOutput("tbl_t1_row", 32'(out_row), 32'd0);
            checkOutput("tbl_t1_data", out_data, vecs[i].row0);
            checkOutput("tbl_t1_sat", 32'(out_sat), 32'(vecs[i].sat0));
            checkOutput("tbl_t1_clear", 32'(acc_clear), 32'd1);
            checkOutput("tbl_t1_busy", 32'(busy), 32'd1);
            step();
            checkOutput("tbl_t2_row", 32'(out_row), 32'd1);
            checkOutput("tbl_t2_last", 32'(out_last), 32'd1);
            checkOutput("tbl_t2_data", out_data, vecs[i].row1);
            checkOutput("tbl_t2_sat", 32'(out_sat), 32'(vecs[i].sat1));
            checkOutput("tbl_t2_clear", 32'(acc_clear), 32'd0);
            step();
            checkOutput("tbl_t3_valid", 32'(out_valid), 32'd0);
            checkOutput("tbl_t3_busy", 32'(busy), 32'd0);
        end

        // Backpressure: row 0 must hold for five cycles
        m = pack4(1, 2, 3, 4);
        applyStimulus(m, 1'b1, 1'b0);
        pushMatrix(1, 2, 3, 4);
        step();
        applyStimulus(m, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_hold_row", 32'(out_row), 32'd0);
            checkOutput("bp_hold_data", out_data, 32'h0002_0001);
            checkOutput("bp_hold_clear", 32'(acc_clear), (k == 0) ? 32'd1 : 32'd0);
            if (k < 4) step();
        end
        applyStimulus(m, 1'b0, 1'b1);
        step();
        checkOutput("bp_row1_row", 32'(out_row), 32'd1);
        checkOutput("bp_row1_data", out_data, 32'h0004_0003);
        step();
        checkOutput("bp_idle_valid", 32'(out_valid), 32'd0);

        // Back-to-back capture on the row-1 handshake
        m = pack4(10, 20, 30, 40);
        applyStimulus(m, 1'b1, 1'b1);
        pushMatrix(10, 20, 30, 40);
        step();
        applyStimulus(m, 1'b0, 1'b1);
        step();
        checkOutput("b2b_a_row1", 32'(out_row), 32'd1);
        m = pack4(5, 6, 7, 8);
        applyStimulus(m, 1'b1, 1'b1);
        pushMatrix(5, 6, 7, 8);
        step();
        applyStimulus(m, 1'b0, 1'b1);
        checkOutput("b2b_b_row", 32'(out_row), 32'd0);
        checkOutput("b2b_b_data", out_data, 32'h0006_0005);
        checkOutput("b2b_b_clear", 32'(acc_clear), 32'd1);
        checkOutput("b2b_b_busy", 32'(busy), 32'd1);
        checkOutput("b2b_b_drop", 32'(drop_err), 32'd0);
        step();
        checkOutput("b2b_b_row1_data", out_data, 32'h0008_0007);
        checkOutput("b2b_b_row1_clear", 32'(acc_clear), 32'd0);
        step();
        checkOutput("b2b_idle_busy", 32'(busy), 32'd0);

        // Dropped pulse in ROW0
        m = pack4(-7, 7, -9, 9);
        applyStimulus(m, 1'b1, 1'b0);
        pushMatrix(-7, 7, -9, 9);
        step();
        applyStimulus(pack4(99, 99, 99, 99), 1'b1, 1'b0);
        step();
        applyStimulus(pack4(99, 99, 99, 99), 1'b0, 1'b0);
        checkOutput("drop0_flag", 32'(drop_err), 32'd1);
        checkOutput("drop0_clear", 32'(acc_clear), 32'd0);
        checkOutput("drop0_row", 32'(out_row), 32'd0);
        checkOutput("drop0_data", out_data, 32'h0007_FFF9);
        step();
        checkOutput("drop0_sticky", 32'(drop_err), 32'd1);
        checkOutput("drop0_clear2", 32'(acc_clear), 32'd0);
        out_ready = 1'b1;
        step();
        checkOutput("drop0_row1_data", out_data, 32'h0009_FFF7);
        step();
        checkOutput("drop0_idle_valid", 32'(out_valid), 32'd0);
        checkOutput("drop0_idle_sticky", 32'(drop_err), 32'd1);

        // Reset while holding row 1
        m = pack4(11, 12, 13, 14);
        applyStimulus(m, 1'b1, 1'b1);
        pushMatrix(11, 12, 13, 14);
        step();
        applyStimulus(m, 1'b0, 1'b1);
        step();
        applyStimulus(m, 1'b0, 1'b0);
        step();
        checkOutput("mid_hold_row", 32'(out_row), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        sb.delete();
        checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_drop", 32'(drop_err), 32'd0);
        checkOutput("mid_rst_data", out_data, 32'd0);
        checkOutput("mid_rst_row", 32'(out_row), 32'd0);
        checkOutput("mid_rst_last", 32'(out_last), 32'd0);
        checkOutput("mid_rst_clear", 32'(acc_clear), 32'd0);
        step();
        checkOutput("mid_rst_clear2", 32'(acc_clear), 32'd0);

        // New capture after reset, then a dropped pulse in ROW1 without handshake
        m = pack4(21, 22, 23, 24);
        applyStimulus(m, 1'b1, 1'b1);
        pushMatrix(21, 22, 23, 24);
        step();
        applyStimulus(m, 1'b0, 1'b1);
        checkOutput("post_rst_clear", 32'(acc_clear), 32'd1);
        checkOutput("post_rst_data", out_data, 32'h0016_0015);
        step();
        applyStimulus(pack4(77, 77, 77, 77), 1'b1, 1'b0);
        step();
        applyStimulus(pack4(77, 77, 77, 77), 1'b0, 1'b0);
        checkOutput("drop1_flag", 32'(drop_err), 32'd1);
        checkOutput("drop1_clear", 32'(acc_clear), 32'd0);
        checkOutput("drop1_row", 32'(out_row), 32'd1);
        checkOutput("drop1_data", out_data, 32'h0018_0017);
        out_ready = 1'b1;
        step();
        checkOutput("drop1_idle_valid", 32'(out_valid), 32'd0);
        checkOutput("drop1_idle_sticky", 32'(drop_err), 32'd1);

        // Random matrices with random backpressure
        reset = 1'b1;
        step();
        reset = 1'b0;
        sb.delete();
        for (int n = 0; n < 8; n++) begin
            r00 = rand_elem(); r01 = rand_elem();
            r10 = rand_elem(); r11 = rand_elem();
            m = pack4(r00, r01, r10, r11);
            applyStimulus(m, 1'b1, ($urandom_range(0, 1) != 0));
            pushMatrix(r00, r01, r10, r11);
            step();
            acc_done = 1'b0;
            for (int k = 0; k < 60 && busy; k++) begin
                out_ready = ($urandom_range(0, 1) != 0);
                step();
            end
            checkOutput("rand_drain_done", 32'(busy), 32'd0);
        end
        checkOutput("rand_no_drop", 32'(drop_err), 32'd0);
        checkOutput("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
